// File: rtl/pow_fp16_share_arb_pkg.sv
// Shared types for the FP16 pow-unit arbiter: operand type and in-flight tag.
package pow_arb_pkg;

    localparam int unsigned NUM_REQ_MAX = 8;
    // Sized for the largest supported requester count so every instance can share it.
    localparam int unsigned REQ_ID_W    = $clog2(NUM_REQ_MAX);

    typedef logic [15:0] fp16_t;

    typedef struct packed {
        logic                vld;
        logic [REQ_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/pow_rsp_fifo.sv
// Per-requester response FIFO: DEPTH x 16, registered valid, no fall-through, occupancy count.
module pow_rsp_fifo
    import pow_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       wr_en,
    input  fp16_t                      wr_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output fp16_t                      rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fp16_t           mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic            pop;
    logic [CW-1:0]   count_d;

    assign pop     = rd_en & rd_valid;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count + CW'(wr_en) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
            count    <= count_d;
            rd_valid <= (count_d != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/pow_fp16_share_arb.sv
// Round-robin sharing of one fixed-latency FP16 pow unit with credit-guarded response FIFOs.
// Optional POW_ARB_PERF_CNT_EN adds saturating busy/stall performance counters.
module pow_fp16_share_arb
    import pow_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LAT        = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [15:0]             pu_datain,
    input  logic [15:0]             pu_dataout,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [16*NUM_REQ-1:0]   rsp_data
`ifdef POW_ARB_PERF_CNT_EN
    ,
    output logic [31:0]             perf_busy_cnt,
    output logic [31:0]             perf_stall_cnt
`endif
);

    localparam int unsigned IDW    = REQ_ID_W;
    localparam int unsigned CRED_W = $clog2(FIFO_DEPTH+1);

    logic [CRED_W-1:0] credit_q [NUM_REQ];
    logic [CRED_W-1:0] fifo_cnt [NUM_REQ];
    logic [IDW-1:0]    rr_ptr_q;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] fifo_wr;
    logic [IDW-1:0]    sel;
    logic              any_grant;
    fp16_t             issue_data;
    // Stage 0 sits alongside pu_datain; stages 1..LAT track the unit's pipeline.
    tag_t              tag_q [LAT+1];

    // Lowest eligible index overall is the wrap-around fallback; lowest at/after rr_ptr wins.
    always_comb begin
        eligible   = '0;
        grant      = '0;
        sel        = '0;
        any_grant  = 1'b0;
        issue_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            eligible[j] = resetn && req_valid[j] && (credit_q[j] != '0);
        end
        for (int j = NUM_REQ-1; j >= 0; j--) begin
            if (eligible[j]) begin
                sel       = IDW'(j);
                any_grant = 1'b1;
            end
        end
        for (int j = NUM_REQ-1; j >= 0; j--) begin
            if (eligible[j] && (IDW'(j) >= rr_ptr_q)) sel = IDW'(j);
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = any_grant && (sel == IDW'(j));
            if (grant[j]) issue_data = req_data[16*j +: 16];
        end
    end

    assign req_ready = grant;
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        fifo_wr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_wr[i] = tag_q[LAT].vld && (tag_q[LAT].id == IDW'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rr_ptr_q  <= '0;
            pu_datain <= '0;
            for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr_q  <= (sel == IDW'(NUM_REQ-1)) ? '0 : sel + IDW'(1);
                pu_datain <= issue_data;
            end
            tag_q[0].vld <= any_grant;
            tag_q[0].id  <= sel;
            for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= CRED_W'(FIFO_DEPTH);
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !pop[i]) begin
                    credit_q[i] <= credit_q[i] - CRED_W'(1);
                end else if (!grant[i] && pop[i]) begin
                    credit_q[i] <= credit_q[i] + CRED_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        pow_rsp_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock    (clock),
            .resetn   (resetn),
            .wr_en    (fifo_wr[g]),
            .wr_data  (pu_dataout),
            .rd_en    (rsp_ready[g]),
            .rd_valid (rsp_valid[g]),
            .rd_data  (rsp_data[16*g +: 16]),
            .count    (fifo_cnt[g])
        );

        // Credits plus landed results can never exceed the FIFO size.
        always_ff @(posedge clock) begin
            if (resetn) begin
                assert (int'(credit_q[g]) + int'(fifo_cnt[g]) <= int'(FIFO_DEPTH));
            end
        end
    end

`ifdef POW_ARB_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (!resetn) begin
            perf_busy_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (any_grant && (perf_busy_cnt != '1)) perf_busy_cnt <= perf_busy_cnt + 32'd1;
            // A valid request without a grant can only be blocked by zero credit.
            if ((|req_valid) && !any_grant && (perf_stall_cnt != '1)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pow_fp16_share_arb.sv
// Directed self-checking bench for pow_fp16_share_arb with a behavioural LAT-cycle pow unit.
module tb_pow_fp16_share_arb;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned LAT        = 8;
    localparam int unsigned FIFO_DEPTH = 4;

    logic                  clock;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_data;
    logic [15:0]           pu_datain;
    logic [15:0]           pu_dataout;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [16*NUM_REQ-1:0] rsp_data;
`ifdef POW_ARB_PERF_CNT_EN
    logic [31:0]           perf_busy_cnt;
    logic [31:0]           perf_stall_cnt;
`endif

    int tests;
    int fails;

    pow_fp16_share_arb #(
        .NUM_REQ    (NUM_REQ),
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .pu_datain  (pu_datain),
        .pu_dataout (pu_dataout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data)
`ifdef POW_ARB_PERF_CNT_EN
        ,
        .perf_busy_cnt  (perf_busy_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural pow(x,-0.75) for the operands used here; anything else gets a marker pattern.
    function automatic logic [15:0] pow_model(input logic [15:0] x);
        case (x)
            16'h4C00: return 16'h3000;
            16'h3C00: return 16'h3C00;
            16'h2C00: return 16'h4800;
            default:  return x ^ 16'h00FF;
        endcase
    endfunction

    // Not reset, like the real unit.
    logic [15:0] pu_pipe [LAT];
    always @(posedge clock) begin
        pu_pipe[0] <= pow_model(pu_datain);
        for (int k = 1; k < LAT; k++) pu_pipe[k] <= pu_pipe[k-1];
    end
    assign pu_dataout = pu_pipe[LAT-1];

    // Issued-but-not-popped per requester may never exceed the FIFO size.
    int outst [NUM_REQ];
    bit overflow_seen;
    always @(posedge clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!resetn) begin
                outst[i] <= 0;
            end else begin
                if (outst[i] > int'(FIFO_DEPTH)) overflow_seen <= 1'b1;
                outst[i] <= outst[i] + int'(req_valid[i] && req_ready[i])
                                     - int'(rsp_valid[i] && rsp_ready[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        resetn    = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_data  = '0;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        req_data  = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        repeat (2) tick();
        tests++;
        if (req_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        tests++;
        if (rsp_valid !== 4'b0000) begin
            fails++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid);
        end
        tests++;
        if (pu_datain !== 16'h0000) begin
            fails++; $display("FAIL reset_pu_datain got %h want 0000", pu_datain);
        end
        reset_dut();
        req_valid = '1;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL reset_first_grant got %b want 0001", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_op();
        reset_dut();
        req_valid = 4'b0001;
        req_data  = {48'h0, 16'h4C00};
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            fails++; $display("FAIL single_grant got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        tests++;
        if (pu_datain !== 16'h4C00) begin
            fails++; $display("FAIL single_pu_datain got %h want 4c00", pu_datain);
        end
        repeat (8) tick();
        tests++;
        if (rsp_valid !== 4'b0000) begin
            fails++; $display("FAIL single_early_valid cycle9 got %b want 0000", rsp_valid);
        end
        tick();
        tests++;
        if (rsp_valid !== 4'b0001) begin
            fails++; $display("FAIL single_valid cycle10 got %b want 0001", rsp_valid);
        end
        tests++;
        if (rsp_data[15:0] !== 16'h3000) begin
            fails++; $display("FAIL single_data got %h want 3000", rsp_data[15:0]);
        end
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        #1;
        tests++;
        if (rsp_valid !== 4'b0000) begin
            fails++; $display("FAIL single_pop got %b want 0000", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_rr [NUM_REQ];
        int          cnt [NUM_REQ];
        logic [3:0]  one;
        logic [3:0]  exp_g;
        exp_rr[0] = 16'h3C00; exp_rr[1] = 16'h4800; exp_rr[2] = 16'h3000; exp_rr[3] = 16'h3C00;
        for (int i = 0; i < NUM_REQ; i++) cnt[i] = 0;
        one = 4'b0001;
        reset_dut();
        req_data  = {16'h3C00, 16'h4C00, 16'h2C00, 16'h3C00};
        rsp_ready = '1;
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_g = one << (k % NUM_REQ);
            tests++;
            if (req_ready !== exp_g) begin
                fails++; $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, exp_g);
            end
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 15; c++) begin
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rsp_valid[i]) begin
                    cnt[i]++;
                    tests++;
                    if (rsp_data[16*i +: 16] !== exp_rr[i]) begin
                        fails++;
                        $display("FAIL rr_data port%0d got %h want %h",
                                 i, rsp_data[16*i +: 16], exp_rr[i]);
                    end
                end
            end
            tick();
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            tests++;
            if (cnt[i] != 2) begin
                fails++; $display("FAIL rr_count port%0d got %0d want 2", i, cnt[i]);
            end
        end
    endtask

    task automatic test_credit_throttle();
        logic [15:0] d1;
        int          g1;
        int          g2;
        bit          hs1;
        bit          miss2;
        reset_dut();
        d1 = 16'h1000; g1 = 0; g2 = 0; miss2 = 0;
        rsp_ready = 4'b0100;
        for (int c = 0; c < 24; c++) begin
            req_valid = {1'b0, (c >= 8 && c % 4 == 0), 1'b1, 1'b0};
            req_data  = {16'h0000, 16'h2000, d1, 16'h0000};
            #1;
            hs1 = req_ready[1];
            if (hs1) g1++;
            if (req_ready[2]) g2++;
            if (req_valid[2] && !req_ready[2]) miss2 = 1;
            tick();
            if (hs1) d1 = d1 + 16'h0100;
        end
        #1;
        tests++;
        if (g1 != 4) begin
            fails++; $display("FAIL throttle_grants1 got %0d want 4", g1);
        end
        tests++;
        if (req_ready[1] !== 1'b0) begin
            fails++; $display("FAIL throttle_blocked got %b want 0", req_ready[1]);
        end
        tests++;
        if (g2 != 4 || miss2) begin
            fails++; $display("FAIL throttle_req2 got %0d grants miss=%0d want 4 miss=0", g2, miss2);
        end
        tests++;
        if (rsp_valid[1] !== 1'b1 || rsp_data[31:16] !== 16'h10FF) begin
            fails++;
            $display("FAIL throttle_head got v=%b d=%h want v=1 d=10ff", rsp_valid[1], rsp_data[31:16]);
        end
        rsp_ready[1] = 1'b1;
        req_valid    = 4'b0010;
        tick();
        rsp_ready[1] = 1'b0;
        #1;
        tests++;
        if (rsp_data[31:16] !== 16'h11FF) begin
            fails++; $display("FAIL throttle_order got %h want 11ff", rsp_data[31:16]);
        end
        g1 = 0;
        for (int c = 0; c < 15; c++) begin
            req_data = {16'h0000, 16'h0000, d1, 16'h0000};
            #1;
            if (req_ready[1]) g1++;
            tick();
        end
        tests++;
        if (g1 != 1) begin
            fails++; $display("FAIL throttle_regrant got %0d want 1", g1);
        end
        req_valid = '0;
    endtask

    task automatic test_grant_pop();
        logic [15:0] ops [3];
        logic [15:0] exp_q [4];
        int          n;
        ops[0] = 16'h2C00; ops[1] = 16'h3C00; ops[2] = 16'h4C00;
        exp_q[0] = 16'h3C00; exp_q[1] = 16'h3000; exp_q[2] = 16'h00FE; exp_q[3] = 16'h7CFF;
        reset_dut();
        req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            req_data = {48'h0, ops[k]};
            tick();
        end
        req_valid = '0;
        repeat (13) tick();
        tests++;
        if (rsp_valid[0] !== 1'b1 || rsp_data[15:0] !== 16'h4800) begin
            fails++;
            $display("FAIL gp_head got v=%b d=%h want v=1 d=4800", rsp_valid[0], rsp_data[15:0]);
        end
        req_valid = 4'b0001;
        req_data  = {48'h0, 16'h0001};
        rsp_ready = 4'b0001;
        #1;
        tests++;
        if (req_ready[0] !== 1'b1) begin
            fails++; $display("FAIL gp_grant_credit1 got %b want 1", req_ready[0]);
        end
        tick();
        rsp_ready = '0;
        req_data  = {48'h0, 16'h7C00};
        #1;
        tests++;
        if (req_ready[0] !== 1'b1) begin
            fails++; $display("FAIL gp_credit_kept got %b want 1", req_ready[0]);
        end
        tick();
        tests++;
        if (req_ready[0] !== 1'b0) begin
            fails++; $display("FAIL gp_credit_zero got %b want 0", req_ready[0]);
        end
        req_valid = '0;
        repeat (13) tick();
        rsp_ready = 4'b0001;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (rsp_valid[0]) begin
                tests++;
                if (n >= 4 || rsp_data[15:0] !== exp_q[n % 4]) begin
                    fails++;
                    $display("FAIL gp_order idx%0d got %h want %h", n, rsp_data[15:0], exp_q[n % 4]);
                end
                n++;
            end
            tick();
        end
        rsp_ready = '0;
        tests++;
        if (n != 4) begin
            fails++; $display("FAIL gp_drain_count got %0d want 4", n);
        end
    endtask

    task automatic test_reset_midstream();
        bit quiet_bad;
        int g;
        reset_dut();
        req_data  = {16'h3C00, 16'h4C00, 16'h2C00, 16'h3C00};
        rsp_ready = '1;
        req_valid = '1;
        repeat (5) tick();
        req_valid = '0;
        resetn    = 1'b0;
        tick();
        resetn = 1'b1;
        quiet_bad = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (rsp_valid !== 4'b0000) quiet_bad = 1;
            tick();
        end
        tests++;
        if (quiet_bad) begin
            fails++; $display("FAIL midreset_quiet got stale rsp_valid want none");
        end
        rsp_ready = '0;
        req_valid = 4'b0100;
        req_data  = {16'h0000, 16'h4C00, 32'h0};
        g = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready[2]) g++;
            if (c == 9) begin
                tests++;
                if (rsp_valid !== 4'b0000) begin
                    fails++; $display("FAIL midreset_early got %b want 0000", rsp_valid);
                end
            end
            if (c == 10) begin
                tests++;
                if (rsp_valid !== 4'b0100 || rsp_data[47:32] !== 16'h3000) begin
                    fails++;
                    $display("FAIL midreset_latency got v=%b d=%h want v=0100 d=3000",
                             rsp_valid, rsp_data[47:32]);
                end
            end
            tick();
        end
        tests++;
        if (g != 4) begin
            fails++; $display("FAIL midreset_credits got %0d grants want 4", g);
        end
        req_valid = '0;
    endtask

`ifdef POW_ARB_PERF_CNT_EN
    task automatic test_perf();
        reset_dut();
        req_valid = 4'b0001;
        req_data  = {48'h0, 16'h3C00};
        repeat (10) tick();
        req_valid = '0;
        #1;
        tests++;
        if (perf_busy_cnt !== 32'd4) begin
            fails++; $display("FAIL perf_busy got %0d want 4", perf_busy_cnt);
        end
        tests++;
        if (perf_stall_cnt !== 32'd6) begin
            fails++; $display("FAIL perf_stall got %0d want 6", perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        overflow_seen = 0;
        resetn    = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_data  = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_credit_throttle();
        test_grant_pop();
        test_reset_midstream();
`ifdef POW_ARB_PERF_CNT_EN
        test_perf();
`endif
        tests++;
        if (overflow_seen !== 1'b0) begin
            fails++; $display("FAIL fifo_overflow got outstanding above %0d want none", FIFO_DEPTH);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
